// File: rtl/gf180mcu_fd_sc_mcu9t5v0_par2ser_rd_if.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0_par2ser_rd_if.sv - load and serial handshake bundle for the par2ser reader
//
// Purpose: carries the parallel load handshake and the serial readout
// handshake between a flop-bank reader and its neighbours.
// Signals:
//   LOAD_DATA  [WIDTH] parallel word from the flop bank
//   LOAD_VALID         LOAD_DATA is valid
//   LOAD_READY         reader can accept a word
//   SOUT               current serial bit
//   SOUT_VALID         SOUT holds a valid bit
//   SOUT_READY         consumer accepts SOUT this cycle
//   SOUT_LAST          current bit is the final bit of the word
//   BUSY               a word is being shifted
// Modports: slave = the reader, master = the environment around it.
interface gf180mcu_fd_sc_mcu9t5v0_par2ser_rd_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] LOAD_DATA;
  logic             LOAD_VALID;
  logic             LOAD_READY;
  logic             SOUT;
  logic             SOUT_VALID;
  logic             SOUT_READY;
  logic             SOUT_LAST;
  logic             BUSY;

  modport slave (
    input  LOAD_DATA, LOAD_VALID, SOUT_READY,
    output LOAD_READY, SOUT, SOUT_VALID, SOUT_LAST, BUSY
  );

  modport master (
    output LOAD_DATA, LOAD_VALID, SOUT_READY,
    input  LOAD_READY, SOUT, SOUT_VALID, SOUT_LAST, BUSY
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0_par2ser_rd.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0_par2ser_rd.sv - parallel-capture / serial-readout of a set-type flop bank
//
// Purpose: captures a WIDTH-bit word in one load handshake and shifts it
// out one bit per accepted beat. Idle serial level is 1, matching the
// preset state of the bank being read.
// Ports:
//   CLK  rising-edge clock
//   RST  synchronous active-high reset
//   VDD  power pin, no functional effect
//   VSS  ground pin, no functional effect
//   bus  slave side of the load/serial handshake bundle
// Parameters:
//   WIDTH      bits per word, 2..64
//   MSB_FIRST  1 = bit WIDTH-1 leaves first, 0 = bit 0 leaves first
module gf180mcu_fd_sc_mcu9t5v0_par2ser_rd #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic VDD,
  input  logic VSS,
  gf180mcu_fd_sc_mcu9t5v0_par2ser_rd_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             out_bit;

  // Supply pins are kept for netlist compatibility only.
  logic unused_pins;
  assign unused_pins = VDD ^ VSS;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      shreg <= '1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.LOAD_VALID) begin
          shreg_nxt = bus.LOAD_DATA;
          cnt_nxt   = CW'(WIDTH - 1);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // LOAD_VALID is deliberately ignored here; the upstream holds it.
        if (bus.SOUT_READY) begin
          if (cnt == '0) begin
            state_nxt = IDLE;
          end else begin
            // Shift toward the output end, back-filling with the idle level.
            if (MSB_FIRST) begin
              shreg_nxt = {shreg[WIDTH-2:0], 1'b1};
            end else begin
              shreg_nxt = {1'b1, shreg[WIDTH-1:1]};
            end
            cnt_nxt = cnt - CW'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign out_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

  // All outputs decode registered state only. SOUT is forced to 1 in IDLE
  // because the register may still hold the last (possibly 0) bit.
  assign bus.LOAD_READY = (state == IDLE);
  assign bus.BUSY       = (state == SHIFT);
  assign bus.SOUT_VALID = (state == SHIFT);
  assign bus.SOUT       = (state == SHIFT) ? out_bit : 1'b1;
  assign bus.SOUT_LAST  = (state == SHIFT) && (cnt == '0);

endmodule
